// File: rtl/gearbox_256i_16o_pkg.sv
// Shared gearbox constants and slice helper.
// Also used by the read-side DDR arbiter.
package gearbox_256i_16o_pkg;

  localparam int GB_IN_WIDTH  = 256;
  localparam int GB_OUT_WIDTH = 16;
  localparam int GB_RATIO     = GB_IN_WIDTH / GB_OUT_WIDTH;
  localparam int GB_CNT_W     = $clog2(GB_RATIO);

  function automatic logic [GB_OUT_WIDTH-1:0] gb_slice(
    input logic [GB_IN_WIDTH-1:0] w,
    input logic [GB_CNT_W-1:0]    k
  );
    return w[k*GB_OUT_WIDTH +: GB_OUT_WIDTH];
  endfunction

endpackage

// File: rtl/gearbox_256i_16o.sv
// 256-to-16 width-narrowing gearbox, LSB slice first.
// One output slice per cycle, back-to-back input words.
module gearbox_256i_16o
  import gearbox_256i_16o_pkg::*;
#(
  parameter int IN_WIDTH  = GB_IN_WIDTH,
  parameter int OUT_WIDTH = GB_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = $clog2(RATIO);

  logic [IN_WIDTH-1:0] word_q;
  logic                last_q;
  logic                loaded;
  logic [CNT_W-1:0]    idx;

  logic last_idx;
  logic in_fire;
  logic out_fire;

  assign last_idx = (idx == CNT_W'(RATIO - 1));
  assign out_fire = loaded & out_ready;
  assign in_fire  = in_valid & in_ready;

  // Ready on the final slice lets the next word follow with no bubble.
  assign in_ready = !rst & !flush & (!loaded | (out_fire & last_idx));

  assign out_valid = loaded;
  assign out_data  = word_q[idx*OUT_WIDTH +: OUT_WIDTH];
  assign out_last  = loaded & last_q & last_idx;
  assign busy      = loaded;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      last_q <= 1'b0;
      loaded <= 1'b0;
      idx    <= '0;
    end else if (flush) begin
      loaded <= 1'b0;
      idx    <= '0;
    end else begin
      if (out_fire) begin
        if (!last_idx) begin
          idx <= idx + CNT_W'(1);
        end else begin
          idx    <= '0;
          loaded <= 1'b0;
        end
      end
      if (in_fire) begin
        word_q <= in_data;
        last_q <= in_last;
        idx    <= '0;
        loaded <= 1'b1;
      end
    end
  end

endmodule
